prg_saver: RTL and testbench

Streams a region of PET RAM out as a PRG file, performing the inverse of the PRG loader: it reads the BASIC start pointer ($28/$29) and end pointer ($2A/$2B), then emits a 2-byte little-endian load address followed by the program bytes. It sits between the `pet2001hw` DMA port, used as a reader, and the HPS upload path, which acts as a byte sink. It runs on `clk_sys`, alongside the loader.

---
 rtl/pet_pkg.sv | 33 +++
 rtl/prg_saver.sv | 180 ++++++++++++++++++
 tb/tb_prg_saver.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pet_pkg.sv
// Shared PET-side types and constants for the PRG save path.
package pet_pkg;

   localparam int unsigned PET_ADDR_W  = 16;
   localparam int unsigned PET_DATA_W  = 8;
   localparam int unsigned FILE_ADDR_W = 25;

   localparam logic [PET_ADDR_W-1:0] TXTTAB_ADDR = 16'h0028;
   localparam logic [PET_ADDR_W-1:0] PET_RAM_TOP = 16'h8000;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      PTR   = 4'd1,
      CHECK = 4'd2,
      HDR0  = 4'd3,
      HDR1  = 4'd4,
      RD    = 4'd5,
      CAP   = 4'd6,
      SEND  = 4'd7,
      DONE  = 4'd8
   } prg_state_t;

   // BASIC text pointers, laid out so byte k of the pointer block is bits [8k +: 8]
   typedef struct packed {
      logic [PET_ADDR_W-1:0] e_ptr;
      logic [PET_ADDR_W-1:0] s_ptr;
   } prg_ptrs_t;

   function automatic logic prg_range_bad(input prg_ptrs_t p, input logic [PET_ADDR_W-1:0] top);
      return (p.e_ptr < p.s_ptr) || (p.e_ptr > top);
   endfunction

endpackage

// File: rtl/prg_saver.sv
// Streams the BASIC program region of PET RAM out as a PRG file
// (2-byte little-endian load address followed by the program bytes).
module prg_saver
   import pet_pkg::*;
#(
   parameter logic [PET_ADDR_W-1:0] PTR_BASE = TXTTAB_ADDR,
   parameter logic [PET_ADDR_W-1:0] RAM_TOP  = PET_RAM_TOP
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [PET_ADDR_W-1:0]  mem_addr,
   output logic                   mem_rd,
   input  logic [PET_DATA_W-1:0]  mem_data,
   output logic [PET_DATA_W-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic [FILE_ADDR_W-1:0] out_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned PTR_CNT_W = 3;

   prg_state_t             state_q, state_d;
   logic [PTR_CNT_W-1:0]   cnt_q, cnt_d;
   prg_ptrs_t              ptrs_q, ptrs_d;
   logic [PET_ADDR_W-1:0]  cur_q, cur_d;

   logic [PET_ADDR_W-1:0]  mem_addr_d;
   logic                   mem_rd_d;
   logic [PET_DATA_W-1:0]  out_data_d;
   logic                   out_valid_d;
   logic                   out_last_d;
   logic [FILE_ADDR_W-1:0] out_addr_d;
   logic                   busy_d;
   logic                   done_d;
   logic                   err_d;

   logic                   xfer_c;
   logic                   range_bad_c;
   logic                   empty_c;

   // Abort wins over a simultaneous handshake, so the byte is not consumed
   assign xfer_c      = out_valid & out_ready & ~abort;
   assign range_bad_c = prg_range_bad(ptrs_q, RAM_TOP);
   assign empty_c     = (ptrs_q.e_ptr == ptrs_q.s_ptr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = PTR;
         PTR:     if (cnt_q == PTR_CNT_W'(7)) state_d = CHECK;
         CHECK:   state_d = range_bad_c ? DONE : HDR0;
         HDR0:    if (xfer_c) state_d = HDR1;
         HDR1:    if (xfer_c) state_d = empty_c ? DONE : RD;
         RD:      state_d = CAP;
         CAP:     state_d = SEND;
         SEND:    if (xfer_c) state_d = out_last ? DONE : RD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // Next values of datapath and registered outputs, keyed on current and next state
   always_comb begin
      cnt_d       = cnt_q;
      ptrs_d      = ptrs_q;
      cur_d       = cur_q;
      mem_addr_d  = mem_addr;
      mem_rd_d    = 1'b0;
      out_data_d  = out_data;
      out_last_d  = out_last;
      out_addr_d  = out_addr;
      err_d       = err;
      out_valid_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == SEND);
      busy_d      = (state_d != IDLE) && (state_d != DONE);
      done_d      = (state_d == DONE);

      case (state_q)
         IDLE: begin
            if (state_d == PTR) begin
               cnt_d = '0;
               err_d = 1'b0;
            end
         end
         PTR: begin
            cnt_d = cnt_q + PTR_CNT_W'(1);
            // Odd cycles carry the data for the read issued on the previous cycle
            if (cnt_q[0]) ptrs_d[{cnt_q[2:1], 3'b000} +: PET_DATA_W] = mem_data;
         end
         CHECK: begin
            if (state_d == DONE) err_d = 1'b1;
            if (state_d == HDR0) cur_d = ptrs_q.s_ptr;
         end
         SEND: begin
            if (xfer_c) cur_d = cur_q + PET_ADDR_W'(1);
         end
         default: ;
      endcase

      if (xfer_c) out_addr_d = out_addr + FILE_ADDR_W'(1);

      case (state_d)
         PTR: begin
            if (!cnt_d[0]) begin
               mem_rd_d   = 1'b1;
               mem_addr_d = PTR_BASE + PET_ADDR_W'(cnt_d[2:1]);
            end
         end
         HDR0: begin
            if (state_q != HDR0) begin
               out_data_d = ptrs_q.s_ptr[7:0];
               out_last_d = 1'b0;
               out_addr_d = '0;
            end
         end
         HDR1: begin
            if (state_q != HDR1) begin
               out_data_d = ptrs_q.s_ptr[15:8];
               out_last_d = empty_c;
            end
         end
         RD: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = cur_d;
         end
         SEND: begin
            if (state_q == CAP) begin
               out_data_d = mem_data;
               out_last_d = ((cur_q + PET_ADDR_W'(1)) == ptrs_q.e_ptr);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         ptrs_q    <= '0;
         cur_q     <= '0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ptrs_q    <= ptrs_d;
         cur_q     <= cur_d;
         mem_addr  <= mem_addr_d;
         mem_rd    <= mem_rd_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
         out_addr  <= out_addr_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_prg_saver.sv
// Directed self-checking bench for prg_saver with a 1-cycle-latency RAM model.
module tb_prg_saver;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [24:0] out_addr;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ram [0:65535];
   logic [7:0]  got_data [$];
   logic        got_last [$];
   logic [24:0] got_addr [$];
   int          done_cnt    = 0;
   int          overlap_cnt = 0;
   int          stall_viol  = 0;
   logic        prev_stall  = 1'b0;
   logic [7:0]  prev_data   = '0;
   logic        prev_last   = 1'b0;
   logic [24:0] prev_addr   = '0;

   prg_saver dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_addr  (out_addr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_data <= ram[mem_addr];
   end

   // Stream monitor: records accepted bytes, done pulses and protocol violations
   always @(posedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready && !abort) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_addr.push_back(out_addr);
         end
         if (done) done_cnt++;
         if (mem_rd && out_valid) overlap_cnt++;
         if (prev_stall && (!out_valid || out_data !== prev_data ||
                            out_last !== prev_last || out_addr !== prev_addr))
            stall_viol++;
         prev_stall = out_valid && !out_ready && !abort;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_addr  = out_addr;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
      ram[16'h0028] = s[7:0];
      ram[16'h0029] = s[15:8];
      ram[16'h002A] = e[7:0];
      ram[16'h002B] = e[15:8];
   endtask

   task automatic run_xfer(input bit toggle, input int restart_at, output int cycles,
                           output bit timed_out, output logic busy_at1);
      cycles    = 0;
      timed_out = 1'b1;
      busy_at1  = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         start = (n == restart_at);
         if (toggle) out_ready = ~out_ready;
         if (n == 1) busy_at1 = busy;
         if (done) begin
            cycles    = n;
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_addr, mem_rd, out_data, out_valid, out_last, out_addr, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%h rd=%b data=%h v=%b l=%b oa=%0d busy=%b done=%b err=%b, want all 0",
                  mem_addr, mem_rd, out_data, out_valid, out_last, out_addr, busy, done, err);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [6] = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      int   base, dbase, cyc;
      bit   to;
      logic b1;
      set_ptrs(16'h0401, 16'h0405);
      ram[16'h0401] = 8'hAA; ram[16'h0402] = 8'hBB;
      ram[16'h0403] = 8'hCC; ram[16'h0404] = 8'hDD;
      out_ready = 1'b1;
      base  = got_data.size();
      dbase = done_cnt;
      run_xfer(1'b0, 0, cyc, to, b1);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
      checks++;
      if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", b1); end
      checks++;
      if (cyc != 24) begin errors++; $display("FAIL basic_latency: got %0d cycles want 24", cyc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
      @(negedge clk);
      checks++;
      if (got_data.size() - base != 6) begin
         errors++; $display("FAIL basic_len: got %0d want 6", got_data.size() - base);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (base + i >= got_data.size() ||
             {got_data[base+i], got_last[base+i], got_addr[base+i]} !== {exp_d[i], (i == 5), 25'(i)}) begin
            errors++;
            $display("FAIL basic_byte%0d: got %h/%b/%0d want %h/%b/%0d", i,
                     got_data[base+i], got_last[base+i], got_addr[base+i], exp_d[i], (i == 5), i);
         end
      end
      checks++;
      if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - dbase); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
   endtask

   task automatic test_empty();
      int   base, dbase, cyc;
      bit   to;
      logic b1;
      set_ptrs(16'h0401, 16'h0401);
      out_ready = 1'b1;
      base  = got_data.size();
      dbase = done_cnt;
      run_xfer(1'b0, 0, cyc, to, b1);
      checks++;
      if (to || cyc != 12) begin errors++; $display("FAIL empty_latency: got %0d (timeout=%b) want 12", cyc, to); end
      @(negedge clk);
      checks++;
      if (got_data.size() - base != 2) begin
         errors++; $display("FAIL empty_len: got %0d want 2", got_data.size() - base);
      end
      checks++;
      if (base + 1 >= got_data.size() ||
          {got_data[base], got_last[base], got_data[base+1], got_last[base+1], got_addr[base+1]}
          !== {8'h01, 1'b0, 8'h04, 1'b1, 25'd1}) begin
         errors++;
         $display("FAIL empty_bytes: got %h/%b %h/%b want 01/0 04/1",
                  got_data[base], got_last[base], got_data[base+1], got_last[base+1]);
      end
      checks++;
      if (done_cnt - dbase != 1) begin errors++; $display("FAIL empty_done: got %0d want 1", done_cnt - dbase); end
   endtask

   task automatic test_bad_ptr();
      logic [15:0] ends [2] = '{16'h0400, 16'h8001};
      int   base, dbase, cyc;
      bit   to;
      logic b1;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_ptrs(16'h0401, ends[k]);
         base  = got_data.size();
         dbase = done_cnt;
         run_xfer(1'b0, 0, cyc, to, b1);
         checks++;
         if (to || cyc != 10) begin errors++; $display("FAIL bad%0d_latency: got %0d (timeout=%b) want 10", k, cyc, to); end
         @(negedge clk);
         checks++;
         if (got_data.size() != base) begin errors++; $display("FAIL bad%0d_nobytes: got %0d want 0", k, got_data.size() - base); end
         checks++;
         if (done_cnt - dbase != 1) begin errors++; $display("FAIL bad%0d_done: got %0d want 1", k, done_cnt - dbase); end
         checks++;
         if (err !== 1'b1) begin errors++; $display("FAIL bad%0d_err: got %b want 1", k, err); end
      end
      set_ptrs(16'h0401, 16'h0401);
      run_xfer(1'b0, 0, cyc, to, b1);
      checks++;
      if (err !== 1'b0 || to) begin errors++; $display("FAIL bad_err_clear: got err=%b timeout=%b want 0/0", err, to); end
   endtask

   task automatic test_stall();
      logic [7:0] exp_d [4] = '{8'hFE, 8'h7F, 8'h11, 8'h22};
      int   base, sbase, cyc;
      bit   to;
      logic b1;
      set_ptrs(16'h7FFE, 16'h8000);
      ram[16'h7FFE] = 8'h11;
      ram[16'h7FFF] = 8'h22;
      out_ready = 1'b1;
      base  = got_data.size();
      sbase = stall_viol;
      run_xfer(1'b1, 0, cyc, to, b1);
      out_ready = 1'b1;
      checks++;
      if (to) begin errors++; $display("FAIL stall_timeout: no done within budget"); end
      @(negedge clk);
      checks++;
      if (got_data.size() - base != 4) begin
         errors++; $display("FAIL stall_len: got %0d want 4", got_data.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (base + i >= got_data.size() ||
             {got_data[base+i], got_last[base+i], got_addr[base+i]} !== {exp_d[i], (i == 3), 25'(i)}) begin
            errors++;
            $display("FAIL stall_byte%0d: got %h/%b/%0d want %h/%b/%0d", i,
                     got_data[base+i], got_last[base+i], got_addr[base+i], exp_d[i], (i == 3), i);
         end
      end
      checks++;
      if (stall_viol != sbase) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol - sbase); end
   endtask

   task automatic test_abort();
      logic [7:0] exp_d [6] = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      int   base, dbase, cyc;
      bit   found, to;
      logic b1;
      set_ptrs(16'h0401, 16'h0405);
      out_ready = 1'b1;
      base  = got_data.size();
      dbase = done_cnt;
      found = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && out_addr == 25'd2) begin found = 1'b1; break; end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (!found) begin errors++; $display("FAIL abort_reach: third byte never presented"); end
      checks++;
      if ({out_valid, busy, mem_rd} !== 3'b000) begin
         errors++; $display("FAIL abort_drop: got valid=%b busy=%b rd=%b want 000", out_valid, busy, mem_rd);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt != dbase || got_data.size() - base != 2) begin
         errors++; $display("FAIL abort_nodone: got done=%0d bytes=%0d want 0/2", done_cnt - dbase, got_data.size() - base);
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err); end
      base = got_data.size();
      run_xfer(1'b0, 0, cyc, to, b1);
      @(negedge clk);
      checks++;
      if (to || got_data.size() - base != 6) begin
         errors++; $display("FAIL abort_rerun_len: got %0d (timeout=%b) want 6", got_data.size() - base, to);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (base + i >= got_data.size() || got_data[base+i] !== exp_d[i]) begin
            errors++; $display("FAIL abort_rerun_byte%0d: got %h want %h", i, got_data[base+i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int   base, dbase, cyc;
      bit   to;
      logic b1;
      set_ptrs(16'h0401, 16'h0405);
      out_ready = 1'b1;
      dbase = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_addr, mem_rd, out_data, out_valid, out_last, out_addr, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got addr=%h rd=%b busy=%b data=%h, want all 0", mem_addr, mem_rd, busy, out_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt != dbase || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_idle: got done=%0d busy=%b want 0/0", done_cnt - dbase, busy);
      end
      base  = got_data.size();
      dbase = done_cnt;
      run_xfer(1'b0, 5, cyc, to, b1);
      checks++;
      if (to || cyc != 24) begin errors++; $display("FAIL restart_ignored_latency: got %0d (timeout=%b) want 24", cyc, to); end
      // start coincident with the done pulse must not launch a new transfer
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_on_done: got busy=%b want 0", busy); end
      checks++;
      if (got_data.size() - base != 6 || done_cnt - dbase != 1) begin
         errors++; $display("FAIL restart_ignored_stream: got bytes=%0d done=%0d want 6/1", got_data.size() - base, done_cnt - dbase);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_bad_ptr();
      test_stall();
      test_abort();
      test_reset_mid();
      checks++;
      if (overlap_cnt != 0) begin errors++; $display("FAIL rd_during_valid: got %0d cycles want 0", overlap_cnt); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
